// File: rtl/fetch_pc_redirect.sv
// Next-PC / fetch-address unit. Issues sequential fetch addresses, applies
// taken branch/jump redirects after the MIPS delay slot has been issued, and
// applies exception/eret flush redirects with top priority.
module fetch_pc_redirect #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hBFC0_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_pc_i,
  input  logic              id_branch_i,
  input  logic              id_equal_i,
  input  logic              id_jump_i,
  input  logic [ADDR_W-1:0] id_target_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_addr_ok_i
);

  localparam logic [ADDR_W-1:0] Four  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] Eight = ADDR_W'(8);

  typedef enum logic [0:0] {StRun, StWaitDs} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  logic              take;
  logic [ADDR_W-1:0] b_plus4;
  logic [ADDR_W-1:0] b_plus8;
  logic              ds_pending;
  logic              ds_issued;
  logic              kill;
  logic              accept;

  // Branch decode relative to the current fetch pc (all sums wrap modulo 2^ADDR_W).
  always_comb begin
    take       = id_valid_i & (id_jump_i | (id_branch_i & id_equal_i));
    b_plus4    = id_pc_i + Four;
    b_plus8    = id_pc_i + Eight;
    ds_pending = (state_q == StRun) & take & (pc_q == b_plus4);
    ds_issued  = (state_q == StRun) & take & (pc_q == b_plus8);
    // B+8 is the wrong-path fetch unless the target happens to be B+8 itself.
    kill       = ds_issued & (id_target_i != b_plus8);
  end

  // State register: pc, redirect state and latched target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state: flush beats stall, stall beats the branch logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    if (flush_i) begin
      state_d = StRun;
      pc_d    = flush_pc_i;
      tgt_d   = '0;
    end else if (!stall_i) begin
      unique case (state_q)
        StRun: begin
          if (ds_pending) begin
            if (accept) begin
              // Delay slot leaves this cycle, so the target is next.
              pc_d = id_target_i;
            end else begin
              tgt_d   = id_target_i;
              state_d = StWaitDs;
            end
          end else if (ds_issued) begin
            // Target equal to B+8 is not killed; if it was accepted, move past it.
            pc_d = accept ? (pc_q + Four) : id_target_i;
          end else if (accept) begin
            pc_d = pc_q + Four;
          end
        end
        StWaitDs: begin
          if (accept) begin
            pc_d    = tgt_q;
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // Outputs: request gating and fetch address.
  always_comb begin
    inst_req_o  = ~rst & ~stall_i & ~flush_i & ~kill;
    inst_addr_o = pc_q;
    accept      = inst_req_o & inst_addr_ok_i;
  end

endmodule
